add_result_buffer: RTL and testbench

- Elastic output stage placed directly downstream of the N-bit ripple-carry adder.
- Captures each adder result (sum plus carry-out) through a valid/ready handshake into a DEPTH-entry FIFO, then presents it to the consumer as a single (N+1)-bit word.
- Keeps a saturating count of carry-out events for overflow monitoring.

---
 rtl/add_result_pkg.sv | 19 +
 rtl/add_result_mem.sv | 28 ++
 rtl/add_result_buffer.sv | 103 ++++++++++
 tb/tb_add_result_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_result_pkg.sv
// Shared widths, defaults and helpers for the adder result buffer.
package add_result_pkg;

  localparam int unsigned N_DEF         = 32;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned CARRY_CNT_W   = 16;
  localparam logic [CARRY_CNT_W-1:0] CARRY_CNT_MAX = 16'hFFFF;

  // Pointer width; a depth of 1 would still need a 1-bit address.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : int'($clog2(depth));
  endfunction

  // Occupancy counter spans 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/add_result_mem.sv
// DEPTH x W register file: synchronous write, asynchronous read, reset to zero.
module add_result_mem #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/add_result_buffer.sv
// Elastic FIFO stage after the ripple-carry adder with a saturating carry-out counter.
// Optional same-cycle bypass when empty: define ADD_RESULT_BUFFER_BYPASS_EN.
module add_result_buffer
  import add_result_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_sum,
  input  logic                   in_carry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N:0]             out_result,
  output logic [$clog2(DEPTH):0] count,
  output logic [CARRY_CNT_W-1:0] carry_events
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned W  = N + 1;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CARRY_CNT_W-1:0] carry_q, carry_d;

  logic         mem_valid;
  logic         bypass;
  logic         accept;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] rdata;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign mem_valid = (count_q != '0);

`ifdef ADD_RESULT_BUFFER_BYPASS_EN
  // Empty buffer with a waiting consumer hands the adder result straight through.
  assign bypass     = !mem_valid && in_valid && out_ready;
  assign out_valid  = mem_valid || bypass;
  assign out_result = bypass ? {in_carry, in_sum} : rdata;
`else
  assign bypass     = 1'b0;
  assign out_valid  = mem_valid;
  assign out_result = rdata;
`endif

  assign accept = in_valid && in_ready;
  assign wr_en  = accept && !bypass;
  assign rd_en  = mem_valid && out_ready;

  add_result_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_carry, in_sum}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    carry_d  = carry_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept && in_carry && (carry_q != CARRY_CNT_MAX)) carry_d = carry_q + CARRY_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      carry_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
    end
  end

  assign count        = count_q;
  assign carry_events = carry_q;

endmodule

// File: tb/tb_add_result_buffer.sv
// Directed bench for add_result_buffer: queue-based reference model plus literal checks.
module tb_add_result_buffer;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;
`ifdef ADD_RESULT_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           in_sum;
  logic                   in_carry;
  logic                   out_valid;
  logic                   out_ready;
  logic [N:0]             out_result;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            carry_events;

  add_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .in_carry     (in_carry),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .count        (count),
    .carry_events (carry_events)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents and carry tally, plus a log of delivered words.
  logic [N:0] q[$];
  logic [N:0] log_q[$];
  int         ev_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_bypass();
    return BYP && (q.size() == 0) && in_valid && out_ready;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    ev_model = 0;
  end

  // Model update on each rising edge using the inputs and model state before the edge.
  logic       stall_prev = 1'b0;
  logic [N:0] stall_word;
  always @(posedge clk) begin
    if (rst_n) begin
      bit byp, acc, rd;
      byp = model_bypass();
      acc = in_valid && (q.size() != DEPTH);
      rd  = (q.size() != 0) && out_ready;
      if (stall_prev && in_valid) chk("upstream_hold", {31'd0, in_carry, in_sum}, {31'd0, stall_word});
      stall_prev = in_valid && !acc;
      stall_word = {in_carry, in_sum};
      if (acc && in_carry && ev_model < 65535) ev_model++;
      if (rd) begin
        log_q.push_back(out_result);
        void'(q.pop_front());
      end
      if (byp) log_q.push_back(out_result);
      if (acc && !byp) q.push_back({in_carry, in_sum});
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit byp;
      byp = model_bypass();
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("out_valid", 64'(out_valid), 64'((q.size() != 0) || byp));
      chk("count", 64'(count), 64'(q.size()));
      chk("carry_events", 64'(carry_events), 64'(ev_model));
      if (q.size() != 0) chk("out_result", 64'(out_result), 64'(q[0]));
      else if (byp) chk("out_result_byp", 64'(out_result), 64'({in_carry, in_sum}));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] s, input logic c, input logic r);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    cyc();

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_carry_events", 64'(carry_events), 64'd0);
    rst_n = 1'b1;
    log_q.delete();

    // Basic pass-through
    drive(1'b1, 32'h0000_0005, 1'b0, 1'b1);
    if (!BYP) begin
      #1 chk("pt_same_cycle_valid", 64'(out_valid), 64'd0);
    end
    cyc();
    drive(1'b0, '0, 1'b0, 1'b1);
    if (!BYP) begin
      chk("pt_next_valid", 64'(out_valid), 64'd1);
      chk("pt_result", 64'(out_result), 64'h0_0000_0005);
    end
    cyc();
    chk("pt_count", 64'(count), 64'd0);
    chk("pt_log_size", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("pt_log0", 64'(log_q[0]), 64'h5);

    // Fill and backpressure
    do_reset();
    drive(1'b1, 32'd1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      in_sum = 32'(i);
      cyc();
    end
    in_sum = 32'd5;
    cyc();
    cyc();
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("fill_ready_after_read", 64'(in_ready), 64'd1);
    chk("fill_count_after_read", 64'(count), 64'd3);
    cyc();
    in_valid = 1'b0;
    chk("fill_count_refill", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    chk("fill_log_size", 64'(log_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) chk("fill_order", 64'(log_q[i]), 64'(i + 1));

    // Simultaneous read/write at pointer wrap
    do_reset();
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    cyc();
    in_sum = 32'h11;
    cyc();
    in_sum = 32'h12;
    cyc();
    drive(1'b0, '0, 1'b0, 1'b1);
    cyc();
    chk("wrap_pre_count", 64'(count), 64'd2);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    cyc();
    chk("wrap_count", 64'(count), 64'd2);
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc();
    chk("wrap_log_size", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      chk("wrap_log0", 64'(log_q[0]), 64'h10);
      chk("wrap_log1", 64'(log_q[1]), 64'h11);
      chk("wrap_log2", 64'(log_q[2]), 64'h12);
      chk("wrap_log3", 64'(log_q[3]), 64'h1_FFFF_FFFF);
      chk("wrap_log4", 64'(log_q[4]), 64'h77);
    end

    // Carry counter and saturation
    do_reset();
    drive(1'b1, 32'h1, 1'b1, 1'b1);
    cyc();
    in_carry = 1'b1;
    cyc();
    in_carry = 1'b0;
    cyc();
    in_carry = 1'b1;
    cyc();
    in_carry = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("carry_three", 64'(carry_events), 64'd3);
    drive(1'b1, 32'h2, 1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) cyc();
    chk("carry_sat", 64'(carry_events), 64'hFFFF);
    for (int i = 0; i < 3; i++) cyc();
    in_valid = 1'b0;
    cyc();
    chk("carry_sat_hold", 64'(carry_events), 64'hFFFF);

    // Reset mid-operation
    do_reset();
    drive(1'b1, 32'h21, 1'b1, 1'b0);
    cyc();
    in_sum = 32'h22;
    cyc();
    in_sum = 32'h23;
    cyc();
    in_valid = 1'b0;
    chk("mid_pre_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_carry", 64'(carry_events), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    chk("mid_no_stale_valid", 64'(out_valid), 64'd0);
    chk("mid_no_stale_result", 64'(out_result), 64'd0);

    // Bypass when empty (or one-cycle latency without it)
    do_reset();
    drive(1'b1, 32'hA, 1'b1, 1'b1);
    #1;
    chk("byp_same_valid", 64'(out_valid), BYP ? 64'd1 : 64'd0);
    if (BYP) chk("byp_same_result", 64'(out_result), 64'h1_0000_000A);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("byp_count", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("byp_next_valid", 64'(out_valid), BYP ? 64'd0 : 64'd1);
    cyc();
    chk("byp_log_size", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) chk("byp_log0", 64'(log_q[0]), 64'h1_0000_000A);
    chk("byp_carry", 64'(carry_events), 64'd1);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
